// File: rtl/aes_pkg.sv
// aes_pkg: shared AES round-state encoding, round-count constants and scheduler FSM states.
package aes_pkg;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;
  typedef struct packed {
    logic       valid;
    logic [3:0] round;
  } state_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;
endpackage

// File: rtl/inflight_counter.sv
// inflight_counter: up/down count of blocks in the round engine, bounded to 0..DEPTH.
module inflight_counter #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [3:0] o_count,
  output logic       o_full,
  output logic       o_empty
);
  logic [3:0] r_count;
  logic       w_up;
  logic       w_dn;
  assign o_count = r_count;
  assign o_full  = r_count >= 4'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_up    = i_inc && !i_dec && !o_full;
  assign w_dn    = i_dec && !i_inc && !o_empty;
  always_ff @(posedge clk)
    if (!n_rst) r_count <= '0;
    else r_count <= w_up ? r_count + 4'd1 : w_dn ? r_count - 4'd1 : r_count;
endmodule

// File: rtl/data_block_scheduler.sv
// data_block_scheduler: picks recirculation, FIFO injection or bubble for the AES round engine each cycle.
// Optional DBS_PERF_CNT_EN adds saturating injection and stall counters.
module data_block_scheduler
  import aes_pkg::*;
#(
  parameter int BLOCK_W    = 128,
  parameter int ROUND_W    = 5,
  parameter int NUM_ROUNDS = NR_AES128,
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_fifo_empty,
  input  logic [BLOCK_W-1:0] i_fifo_block,
  input  logic [TAG_W-1:0]   i_fifo_tag,
  output logic               o_fifo_read,
  input  logic [BLOCK_W-1:0] i_fb_block,
  input  logic [ROUND_W-1:0] i_fb_state,
  input  logic [TAG_W-1:0]   i_fb_tag,
  input  logic               i_flush,
  output logic [BLOCK_W-1:0] o_round_block,
  output logic [ROUND_W-1:0] o_round_state,
  output logic [TAG_W-1:0]   o_round_tag,
  output logic               o_done_valid,
  output logic [BLOCK_W-1:0] o_done_block,
  output logic [TAG_W-1:0]   o_done_tag,
  output logic [3:0]         o_inflight,
  output logic               o_idle
`ifdef DBS_PERF_CNT_EN
  ,
  output logic [15:0]        o_inject_cnt,
  output logic [15:0]        o_stall_cnt
`endif
);
  localparam logic [ROUND_W-1:0] INJ_STATE = {1'b1, {(ROUND_W-1){1'b0}}};
  sched_state_t       r_state;
  logic [BLOCK_W-1:0] r_round_block;
  logic [ROUND_W-1:0] r_round_state;
  logic [TAG_W-1:0]   r_round_tag;
  logic               r_done_valid;
  logic [BLOCK_W-1:0] r_done_block;
  logic [TAG_W-1:0]   r_done_tag;
  logic               w_recirc;
  logic               w_complete;
  logic               w_inject;
  logic               w_full;
  logic               w_empty;
  logic               w_zero_next;
  // Indices beyond the final round are illegal and retire like a normal completion.
  assign w_recirc    = i_fb_state[ROUND_W-1] && (i_fb_state[ROUND_W-2:0] < (ROUND_W-1)'(NUM_ROUNDS));
  assign w_complete  = i_fb_state[ROUND_W-1] && !w_recirc;
  assign w_inject    = n_rst && !i_fifo_empty && !w_recirc && (!w_full || w_complete) &&
                       r_state != DRAIN && !(r_state == RUN && i_flush);
  assign w_zero_next = !w_inject && (w_empty || (o_inflight == 4'd1 && w_complete));
  assign o_fifo_read   = w_inject;
  assign o_round_block = r_round_block;
  assign o_round_state = r_round_state;
  assign o_round_tag   = r_round_tag;
  assign o_done_valid  = r_done_valid;
  assign o_done_block  = r_done_block;
  assign o_done_tag    = r_done_tag;
  assign o_idle        = r_state == IDLE;
  inflight_counter #(.DEPTH(DEPTH)) u_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_inc   (w_inject),
    .i_dec   (w_complete),
    .o_count (o_inflight),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge clk)
    if (!n_rst) begin
      r_state       <= IDLE;
      r_round_block <= '0;
      r_round_state <= '0;
      r_round_tag   <= '0;
      r_done_valid  <= 1'b0;
      r_done_block  <= '0;
      r_done_tag    <= '0;
    end else begin
      r_round_state <= w_recirc ? i_fb_state : w_inject ? INJ_STATE : '0;
      r_round_block <= w_recirc ? i_fb_block : w_inject ? i_fifo_block : r_round_block;
      r_round_tag   <= w_recirc ? i_fb_tag : w_inject ? i_fifo_tag : r_round_tag;
      r_done_valid  <= w_complete;
      r_done_block  <= w_complete ? i_fb_block : r_done_block;
      r_done_tag    <= w_complete ? i_fb_tag : r_done_tag;
      r_state       <= r_state == IDLE ? (w_inject ? RUN : IDLE) :
                       w_zero_next ? IDLE :
                       (r_state == RUN && i_flush) ? DRAIN : r_state;
    end
`ifdef DBS_PERF_CNT_EN
  logic [15:0] r_inject_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_stall;
  assign w_stall      = !i_fifo_empty && (w_recirc || (w_full && !w_complete));
  assign o_inject_cnt = r_inject_cnt;
  assign o_stall_cnt  = r_stall_cnt;
  always_ff @(posedge clk)
    if (!n_rst) begin
      r_inject_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_inject_cnt <= (w_inject && r_inject_cnt != 16'hFFFF) ? r_inject_cnt + 16'd1 : r_inject_cnt;
      r_stall_cnt  <= (w_stall && r_stall_cnt != 16'hFFFF) ? r_stall_cnt + 16'd1 : r_stall_cnt;
    end
`endif
endmodule

// File: tb/tb_data_block_scheduler.sv
// tb_data_block_scheduler: directed stimulus with a launch/done scoreboard checked by a negedge monitor.
module tb_data_block_scheduler;
  logic         clk;
  logic         n_rst;
  logic         i_fifo_empty;
  logic [127:0] i_fifo_block;
  logic [1:0]   i_fifo_tag;
  logic         o_fifo_read;
  logic [127:0] i_fb_block;
  logic [4:0]   i_fb_state;
  logic [1:0]   i_fb_tag;
  logic         i_flush;
  logic [127:0] o_round_block;
  logic [4:0]   o_round_state;
  logic [1:0]   o_round_tag;
  logic         o_done_valid;
  logic [127:0] o_done_block;
  logic [1:0]   o_done_tag;
  logic [3:0]   o_inflight;
  logic         o_idle;
`ifdef DBS_PERF_CNT_EN
  logic [15:0]  o_inject_cnt;
  logic [15:0]  o_stall_cnt;
`endif
  typedef struct packed {
    logic [127:0] b;
    logic [4:0]   s;
    logic [1:0]   t;
  } launch_t;
  typedef struct packed {
    logic [127:0] b;
    logic [1:0]   t;
  } done_t;
  launch_t q_launch[$];
  done_t   q_done[$];
  launch_t e_l;
  done_t   e_d;
  int n_cmp = 0;
  int n_bad = 0;
  int n_pops;
  localparam logic [127:0] BA = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  localparam logic [127:0] BB = 128'hbbbb_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] BC = 128'hcccc_cccc_cccc_cccc_cccc_cccc_cccc_cccc;
  localparam logic [127:0] BD = 128'hd000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] BE = 128'heeee_eeee_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] BF = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
  localparam logic [127:0] BG = 128'h6666_7777_8888_9999_aaaa_bbbb_cccc_dddd;
  localparam logic [127:0] BH = 128'h1234_0000_0000_0000_0000_0000_0000_4321;
  localparam logic [127:0] BI = 128'h9999_0000_0000_0000_0000_0000_0000_9999;
  localparam logic [127:0] BL = 128'h4c00_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] BJ = 128'h4a4a_4a4a_4a4a_4a4a_4a4a_4a4a_4a4a_4a4a;
  localparam logic [127:0] BK = 128'h4b4b_0000_0000_0000_0000_0000_0000_4b4b;

  data_block_scheduler dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_block  (i_fifo_block),
    .i_fifo_tag    (i_fifo_tag),
    .o_fifo_read   (o_fifo_read),
    .i_fb_block    (i_fb_block),
    .i_fb_state    (i_fb_state),
    .i_fb_tag      (i_fb_tag),
    .i_flush       (i_flush),
    .o_round_block (o_round_block),
    .o_round_state (o_round_state),
    .o_round_tag   (o_round_tag),
    .o_done_valid  (o_done_valid),
    .o_done_block  (o_done_block),
    .o_done_tag    (o_done_tag),
    .o_inflight    (o_inflight),
    .o_idle        (o_idle)
`ifdef DBS_PERF_CNT_EN
    ,
    .o_inject_cnt  (o_inject_cnt),
    .o_stall_cnt   (o_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic exp);
    #1;
    chk(name, 128'(o_fifo_read), 128'(exp));
  endtask

  task automatic push_l(input logic [127:0] b, input logic [4:0] s, input logic [1:0] t);
    q_launch.push_back('{b: b, s: s, t: t});
  endtask

  task automatic push_d(input logic [127:0] b, input logic [1:0] t);
    q_done.push_back('{b: b, t: t});
  endtask

  always @(negedge clk) begin
    if (o_round_state[4]) begin
      n_cmp++;
      if (q_launch.size() == 0) begin
        n_bad++;
        $display("FAIL launch_unexpected: got state %0h block %0h, none expected", o_round_state, o_round_block);
      end else begin
        e_l = q_launch.pop_front();
        if ({o_round_block, o_round_state, o_round_tag} !== e_l) begin
          n_bad++;
          $display("FAIL launch: got %0h/%0h/%0h expected %0h/%0h/%0h",
                   o_round_block, o_round_state, o_round_tag, e_l.b, e_l.s, e_l.t);
        end
      end
    end
    if (o_done_valid) begin
      n_cmp++;
      if (q_done.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected: got block %0h, none expected", o_done_block);
      end else begin
        e_d = q_done.pop_front();
        if ({o_done_block, o_done_tag} !== e_d) begin
          n_bad++;
          $display("FAIL done: got %0h/%0h expected %0h/%0h", o_done_block, o_done_tag, e_d.b, e_d.t);
        end
      end
    end
  end

  initial begin
    n_rst = 1'b0; i_fifo_empty = 1'b0; i_fifo_block = BC; i_fifo_tag = 2'd0;
    i_fb_block = '0; i_fb_state = '0; i_fb_tag = '0; i_flush = 1'b0;
    tick; tick;
    rd("rst_read", 1'b0);
    chk("rst_state", 128'(o_round_state), 0);
    chk("rst_block", o_round_block, 0);
    chk("rst_done", 128'(o_done_valid), 0);
    chk("rst_cnt", 128'(o_inflight), 0);
    chk("rst_idle", 128'(o_idle), 1);
    // single block through ten rounds
    n_rst = 1'b1; i_fifo_block = BA; i_fifo_tag = 2'd1;
    push_l(BA, 5'b10000, 2'd1);
    rd("t1_pop", 1'b1);
    tick;
    i_fifo_empty = 1'b1;
    chk("t1_cnt", 128'(o_inflight), 1);
    chk("t1_busy", 128'(o_idle), 0);
    for (int r = 1; r <= 9; r++) begin
      i_fb_block = BA; i_fb_state = {1'b1, 4'(r)}; i_fb_tag = 2'd1;
      push_l(BA, {1'b1, 4'(r)}, 2'd1);
      rd("t1_norecirc_pop", 1'b0);
      tick;
    end
    i_fb_state = 5'b11010;
    push_d(BA, 2'd1);
    tick;
    i_fb_state = '0;
    chk("t1_done_pulse", 128'(o_done_valid), 1);
    chk("t1_cnt0", 128'(o_inflight), 0);
    chk("t1_idle", 128'(o_idle), 1);
    // recirculation beats a non-empty FIFO
    i_fifo_empty = 1'b0; i_fifo_block = BC; i_fifo_tag = 2'd3;
    for (int r = 3; r <= 4; r++) begin
      i_fb_block = BB; i_fb_state = {1'b1, 4'(r)}; i_fb_tag = 2'd2;
      push_l(BB, {1'b1, 4'(r)}, 2'd2);
      rd("t2_no_pop", 1'b0);
      tick;
    end
    i_fb_state = '0;
    chk("t2_cnt", 128'(o_inflight), 0);
    // fill to DEPTH
    n_pops = 0;
    for (int i = 0; i < 6; i++) begin
      i_fifo_block = BD + 128'(i); i_fifo_tag = 2'(i);
      if (i < 4) push_l(BD + 128'(i), 5'b10000, 2'(i));
      rd("t3_pop", i < 4);
      n_pops += int'(o_fifo_read);
      tick;
    end
    chk("t3_pops", 128'(n_pops), 4);
    chk("t3_cnt", 128'(o_inflight), 4);
    // completion plus inject at full count
    i_fifo_block = BE; i_fifo_tag = 2'd3;
    i_fb_block = BD; i_fb_state = 5'b11010; i_fb_tag = 2'd0;
    push_d(BD, 2'd0);
    push_l(BE, 5'b10000, 2'd3);
    rd("t4_pop", 1'b1);
    tick;
    chk("t4_cnt", 128'(o_inflight), 4);
    i_fifo_empty = 1'b1;
    i_fb_block = BF; i_fb_state = 5'b11111; i_fb_tag = 2'd2;
    push_d(BF, 2'd2);
    tick;
    chk("t4_illegal_cnt", 128'(o_inflight), 3);
    i_fb_block = BG; i_fb_state = 5'b11010; i_fb_tag = 2'd1;
    push_d(BG, 2'd1);
    tick;
    chk("t5_cnt2", 128'(o_inflight), 2);
    // flush and drain
    i_fb_state = '0; i_flush = 1'b1; i_fifo_empty = 1'b0; i_fifo_block = BC;
    rd("t5_flush_pop", 1'b0);
    tick;
    i_flush = 1'b0;
    i_fb_block = BH; i_fb_state = 5'b11010; i_fb_tag = 2'd0;
    push_d(BH, 2'd0);
    rd("t5_drain_pop", 1'b0);
    tick;
    chk("t5_drain_busy", 128'(o_idle), 0);
    i_fb_block = BI; i_fb_tag = 2'd3; i_fifo_empty = 1'b1;
    push_d(BI, 2'd3);
    tick;
    i_fb_state = '0;
    chk("t5_idle", 128'(o_idle), 1);
    chk("t5_cnt0", 128'(o_inflight), 0);
    // reset with blocks in flight
    i_fifo_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_fifo_block = BL + 128'(i); i_fifo_tag = 2'(i);
      push_l(BL + 128'(i), 5'b10000, 2'(i));
      rd("t6_pop", 1'b1);
      tick;
    end
    i_fifo_empty = 1'b1;
    chk("t6_cnt3", 128'(o_inflight), 3);
`ifdef DBS_PERF_CNT_EN
    chk("perf_inject", 128'(o_inject_cnt), 9);
    chk("perf_stall", 128'(o_stall_cnt), 4);
`endif
    n_rst = 1'b0;
    tick;
    chk("t6_rst_state", 128'(o_round_state), 0);
    chk("t6_rst_block", o_round_block, 0);
    chk("t6_rst_tag", 128'(o_round_tag), 0);
    chk("t6_rst_done", {o_done_block, 2'b0, o_done_tag}, 0);
    chk("t6_rst_cnt", 128'(o_inflight), 0);
    chk("t6_rst_idle", 128'(o_idle), 1);
    n_rst = 1'b1;
    i_fb_block = BJ; i_fb_state = 5'b11010; i_fb_tag = 2'd3;
    push_d(BJ, 2'd3);
    tick;
    chk("t6_late_done", 128'(o_done_valid), 1);
    chk("t6_late_cnt", 128'(o_inflight), 0);
    i_fb_block = BK; i_fb_state = 5'b10101; i_fb_tag = 2'd0;
    push_l(BK, 5'b10101, 2'd0);
    tick;
    i_fb_state = '0;
    chk("t6_recirc_cnt", 128'(o_inflight), 0);
    chk("t6_recirc_idle", 128'(o_idle), 1);
    tick; tick; tick;
    chk("launch_q_drained", 128'(q_launch.size()), 0);
    chk("done_q_drained", 128'(q_done.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_block_scheduler.md
# data_block_scheduler

Registered, parametrised input scheduler for the AES iterative round datapath. Each cycle it launches the next 128-bit block into the round engine. Candidates are a block returning from the engine for another round, or a fresh block popped from the input FIFO. It also retires blocks whose final round is complete and tracks how many blocks are in flight. It sits between the input FIFO, the round engine output and the round engine input. It supports AES-128/192/256 round counts and a pipelined engine of configurable depth.

## Interface
Parameters:
- BLOCK_W, 128, data block width
- ROUND_W, 5, state width; MSB = valid marker, low ROUND_W-1 bits = round index
- NUM_ROUNDS, 10, final round index (10/12/14)
- DEPTH, 4, maximum blocks in flight (round engine pipeline depth), 1..15
- TAG_W, 2, per-block sideband tag

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous, active-low reset
- i_fifo_empty  in  1  input FIFO empty
- i_fifo_block  in  BLOCK_W  FIFO head block
- i_fifo_tag  in  TAG_W  FIFO head tag
- o_fifo_read  out  1  pop strobe (combinational)
- i_fb_block  in  BLOCK_W  block returned by round engine
- i_fb_state  in  ROUND_W  returned state; MSB=1 means valid
- i_fb_tag  in  TAG_W  returned tag
- i_flush  in  1  stop launches; drain in-flight blocks
- o_round_block  out  BLOCK_W  block launched to engine (registered)
- o_round_state  out  ROUND_W  launched state (registered)
- o_round_tag  out  TAG_W  launched tag (registered)
- o_done_valid  out  1  one-cycle pulse, completed block
- o_done_block  out  BLOCK_W  completed block
- o_done_tag  out  TAG_W  completed tag
- o_inflight  out  4  in-flight count
- o_idle  out  1  FSM in IDLE

## Operation
- Feedback is a completion when i_fb_state MSB=1 and index == NUM_ROUNDS.
- Feedback is recirculation when MSB=1 and index < NUM_ROUNDS.
- Slot priority, evaluated every cycle:
  - Recirculation first: launch i_fb_block/state/tag unchanged. The engine increments the round index.
  - Otherwise inject if the FIFO is non-empty, o_inflight < DEPTH, no completion is suppressed, and the FSM is not DRAIN. Launch i_fifo_block with state {1'b1, 0} (5'b10000 at default) and assert o_fifo_read.
  - Otherwise launch a bubble: block and tag hold their previous value, state = 0.
- A completion frees its slot. Injection in the same cycle is allowed and the count is unchanged.
- Completion: register i_fb_block/tag onto the done outputs and pulse o_done_valid. There is no backpressure; downstream must accept.
- Count: +1 on inject, -1 on completion, net 0 on both. It never exceeds DEPTH and never wraps below 0.
- FSM:
  - IDLE to RUN on first inject.
  - RUN to IDLE when count reaches 0.
  - RUN to DRAIN on i_flush.
  - DRAIN to IDLE when count reaches 0.
  - IDLE ignores i_flush.
  - i_flush held in IDLE has no effect.
- MSB=1 with index > NUM_ROUNDS is illegal. Treat it as a completion.

## Timing
- Reset (n_rst low at clk edge):
  - all outputs 0
  - count 0
  - FSM IDLE, so o_idle=1
  - o_fifo_read=0 while n_rst is low
- Reset mid-operation discards all in-flight blocks. Late feedback is still honoured: recirculations relaunch and completions retire. The count does not go below 0.
- Launch latency: 1 cycle from feedback or FIFO head to o_round_*.
- Done latency: 1 cycle from completing feedback to o_done_valid.
- o_fifo_read asserts in the same cycle the FIFO head is captured.
- Throughput: one launch per cycle.

## Configuration
- DBS_PERF_CNT_EN defined:
  - Adds output o_inject_cnt (16 bit), which counts injections.
  - Adds output o_stall_cnt (16 bit), which counts cycles where the FIFO is non-empty but injection is blocked by a full count or by recirculation.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: both ports and both counters are absent. Behaviour is otherwise identical.

## Structure
- Package aes_pkg holds:
  - the state_t encoding: valid MSB plus round index
  - NR_AES128/192/256 constants (10/12/14)
  - the FSM enum sched_state_t {IDLE, RUN, DRAIN}
- Sub-module inflight_counter: up/down count, bounded at DEPTH, with full/empty flags.

## Test plan
- Reset, then FIFO holds one block, DEPTH=4, NUM_ROUNDS=10:
  - o_fifo_read pulses once.
  - Next cycle o_round_state=5'b10000 and o_inflight=1.
  - Feed back states 1..9 unchanged; each relaunches.
  - Feedback state 5'b11010 gives o_done_valid=1 with the matching block, then o_inflight=0 and o_idle=1.
- FIFO non-empty and recirculation every cycle: o_fifo_read stays 0 and the feedback block is launched.
- FIFO non-empty for 6 cycles with no feedback, DEPTH=4: exactly 4 pops, o_inflight=4, no further pops.
- Completion and FIFO non-empty in the same cycle at count 4: done pulse, one pop, count stays 4.
- i_flush at count 2 with FIFO non-empty: no pops; after 2 completions the FSM is IDLE.
- n_rst low with count 3: all outputs 0 next cycle; a later completion leaves count at 0. With DBS_PERF_CNT_EN, the counters match the injections and stall cycles.
